// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states, Sysbus
// request tag and geometry helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN
    } fetch_state_e;

    localparam logic [3:0]  SYSBUS_READ   = 4'b0001;
    localparam logic [3:0]  SYSBUS_MEMORY = 4'b0001;
    localparam logic [12:0] FETCH_REQ_TAG = (13'(SYSBUS_READ) << 12) | (13'(SYSBUS_MEMORY) << 8);

    function automatic int unsigned lanes_per_beat(input int unsigned bus_w, input int unsigned insn_w);
        return bus_w / insn_w;
    endfunction

    function automatic int unsigned line_bytes(input int unsigned beats, input int unsigned bus_w);
        return beats * bus_w / 8;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Flushable instruction FIFO: up to LANES compacted pushes and one pop per
// cycle, synchronous flush, free-entry count for the fetch issue decision.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int LANES = 2,
    parameter int DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [LANES-1:0]              push_valid,
    input  logic [LANES-1:0][WIDTH-1:0]   push_data,
    input  logic                          pop,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(DEPTH):0]        free_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      push_cnt;
    logic [AW:0]      slot [LANES];
    logic             pop_ok;
    logic [WIDTH-1:0] mem [DEPTH];

    // Valid lanes are packed together so holes in a beat never leave gaps.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i]  = push_cnt;
            push_cnt = push_cnt + (AW+1)'(push_valid[i]);
        end
    end

    assign pop_ok = pop && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_cnt);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            count_d  = count_q + push_cnt - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < LANES; i++) begin
                if (push_valid[i]) begin
                    mem[wr_ptr_q + AW'(slot[i])] <= push_data[i];
                end
            end
        end
    end

    // Combinational read so an entry pushed at one edge is visible the next cycle.
    assign out_data   = mem[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign free_count = (AW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: line bursts on Sysbus, lane split, FIFO and a
// valid/ready instruction output. Optional feature macro: FETCH_ZERO_STOP_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int INSN_WIDTH     = 32,
    parameter int BURST_BEATS    = 8,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSN_WIDTH-1:0]     out_insn,
    output logic [63:0]               out_pc,
    output logic                      halted
);

    localparam int LANES      = int'(lanes_per_beat(BUS_DATA_WIDTH, INSN_WIDTH));
    localparam int LINE_BYTES = int'(line_bytes(BURST_BEATS, BUS_DATA_WIDTH));
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int INSN_BYTES = INSN_WIDTH / 8;
    localparam int BEAT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int FW         = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W    = INSN_WIDTH + 64;

    localparam logic [63:0]       LINE_MASK   = ~(64'(LINE_BYTES) - 64'd1);
    localparam logic [63:0]       INSN_MASK   = ~(64'(INSN_BYTES) - 64'd1);
    localparam logic [FW-1:0]     BURST_INSNS = FW'(BURST_BEATS * LANES);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);

    fetch_state_e        state_q, state_d;
    logic [63:0]         fetch_pc_q, fetch_pc_d;
    logic [63:0]         line_base_q, line_base_d;
    logic [63:0]         req_addr_q, req_addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                reqcyc_q, reqcyc_d;
    logic                respack_q, respack_d;
    logic                drain_pend_q, drain_pend_d;

    logic [63:0]                   lane_addr [LANES];
    logic [INSN_WIDTH-1:0]         lane_insn [LANES];
    logic [LANES-1:0]              lane_keep;
    logic [LANES-1:0]              lane_push;
    logic                          push_en;
    logic [LANES-1:0]              push_valid;
    logic [LANES-1:0][ENTRY_W-1:0] push_data;
    logic                          fifo_valid;
    logic [ENTRY_W-1:0]            fifo_data;
    logic [FW-1:0]                 free_count;
    logic                          pop;
    logic                          last_beat;
    logic                          halt_block;
    logic [63:0]                   redirect_target;
    logic                          unused_ok;

    assign unused_ok       = &{1'b0, bus_resptag};
    assign redirect_target = redirect_pc & INSN_MASK;
    assign last_beat       = (beat_q == LAST_BEAT);
    assign push_en         = (state_q == RESP) && bus_respcyc && !redirect_valid;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_addr[gi]  = line_base_q + 64'(beat_q) * 64'(BEAT_BYTES) + 64'(gi * INSN_BYTES);
            assign lane_insn[gi]  = bus_resp[gi*INSN_WIDTH +: INSN_WIDTH];
            // Only the first line of a fetch can start below fetch_pc.
            assign lane_keep[gi]  = (lane_addr[gi] >= fetch_pc_q);
            assign push_valid[gi] = push_en && lane_push[gi];
            assign push_data[gi]  = {lane_addr[gi], lane_insn[gi]};
        end
    endgenerate

`ifdef FETCH_ZERO_STOP_EN
    logic             halted_q, halted_d;
    logic             stop_q, stop_d;
    logic [LANES-1:0] lane_zero;
    logic [LANES-1:0] zero_upto;

    // A zero lane stops this and every later lane of the burst.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_zero
            assign lane_zero[gi] = lane_keep[gi] && (lane_insn[gi] == '0);
            if (gi == 0) begin : g_first
                assign zero_upto[gi] = lane_zero[gi];
            end else begin : g_rest
                assign zero_upto[gi] = zero_upto[gi-1] | lane_zero[gi];
            end
            assign lane_push[gi] = lane_keep[gi] && !stop_q && !zero_upto[gi];
        end
    endgenerate

    assign halt_block = halted_q;
    assign halted     = halted_q;
`else
    assign lane_push  = lane_keep;
    assign halt_block = 1'b0;
    assign halted     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        line_base_d  = line_base_q;
        req_addr_d   = req_addr_q;
        beat_d       = beat_q;
        reqcyc_d     = reqcyc_q;
        drain_pend_d = drain_pend_q;
        respack_d    = bus_respcyc && ((state_q == RESP) || (state_q == DRAIN));
`ifdef FETCH_ZERO_STOP_EN
        halted_d     = halted_q;
        stop_d       = stop_q;
`endif
        case (state_q)
            IDLE: begin
                if (!redirect_valid && !halt_block && (free_count >= BURST_INSNS)) begin
                    state_d      = REQ;
                    reqcyc_d     = 1'b1;
                    req_addr_d   = fetch_pc_q & LINE_MASK;
                    line_base_d  = fetch_pc_q & LINE_MASK;
                    drain_pend_d = 1'b0;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    drain_pend_d = 1'b1;
                end
                if (bus_reqack) begin
                    reqcyc_d = 1'b0;
                    beat_d   = '0;
                    state_d  = (drain_pend_q || redirect_valid) ? DRAIN : RESP;
`ifdef FETCH_ZERO_STOP_EN
                    stop_d   = 1'b0;
`endif
                end
            end
            RESP: begin
                if (bus_respcyc) begin
                    beat_d = beat_q + BEAT_W'(1);
`ifdef FETCH_ZERO_STOP_EN
                    stop_d = stop_q | (|lane_zero);
`endif
                end
                if (bus_respcyc && last_beat) begin
                    state_d    = IDLE;
                    fetch_pc_d = line_base_q + 64'(LINE_BYTES);
`ifdef FETCH_ZERO_STOP_EN
                    halted_d   = stop_q | (|lane_zero);
`endif
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus_respcyc) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A redirect overrides whatever the burst decided about the next PC.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
`ifdef FETCH_ZERO_STOP_EN
            halted_d   = 1'b0;
            stop_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= entry;
            line_base_q  <= '0;
            req_addr_q   <= '0;
            beat_q       <= '0;
            reqcyc_q     <= 1'b0;
            respack_q    <= 1'b0;
            drain_pend_q <= 1'b0;
`ifdef FETCH_ZERO_STOP_EN
            halted_q     <= 1'b0;
            stop_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            line_base_q  <= line_base_d;
            req_addr_q   <= req_addr_d;
            beat_q       <= beat_d;
            reqcyc_q     <= reqcyc_d;
            respack_q    <= respack_d;
            drain_pend_q <= drain_pend_d;
`ifdef FETCH_ZERO_STOP_EN
            halted_q     <= halted_d;
            stop_q       <= stop_d;
`endif
        end
    end

    assign pop = out_ready && fifo_valid && !redirect_valid;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .LANES (LANES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push_valid (push_valid),
        .push_data  (push_data),
        .pop        (pop),
        .out_valid  (fifo_valid),
        .out_data   (fifo_data),
        .free_count (free_count)
    );

    assign bus_reqcyc  = reqcyc_q;
    assign bus_req     = BUS_DATA_WIDTH'(req_addr_q);
    assign bus_reqtag  = BUS_TAG_WIDTH'(FETCH_REQ_TAG);
    assign bus_respack = respack_q;
    assign out_valid   = fifo_valid;
    assign out_insn    = fifo_data[INSN_WIDTH-1:0];
    assign out_pc      = fifo_data[ENTRY_W-1 -: 64];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a Sysbus memory model plus output collector,
// with hand-computed expected PCs, instructions and request addresses.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] entry = 64'h1000;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_insn;
    logic [63:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [63:0] got_pc[$];
    logic [31:0] got_insn[$];
    logic [63:0] req_q[$];
    int          ack_resp_cnt[$];
    int          respack_cnt = 0;
    int          beats_left = 0;
    int          beat_idx = 0;
    logic [63:0] beat_addr = '0;
    int          redir_at_beat = -1;
    logic [63:0] redir_target = '0;
    logic        redir_req = 1'b0;
    logic [63:0] redir_pc_v = '0;
    logic        zero_en = 1'b0;
    logic [63:0] zero_addr = '0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_respack    (bus_respack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] word(input logic [63:0] a);
        if (zero_en && (a == zero_addr)) return 32'h0;
        return 32'h13 + a[33:2];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        got_pc.delete();
        got_insn.delete();
        req_q.delete();
        ack_resp_cnt.delete();
        respack_cnt = 0;
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b0;
        entry = e;
        wait_cyc(3);
        clear_logs();
        reset = 1'b1;
    endtask

    // Sysbus memory, redirect injection and output collection, all at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus_reqack     = 1'b0;
                bus_respcyc    = 1'b0;
                redirect_valid = 1'b0;
                beats_left     = 0;
                beat_idx       = 0;
            end else begin
                if (bus_respack) respack_cnt++;
                bus_reqack     = 1'b0;
                bus_respcyc    = 1'b0;
                redirect_valid = 1'b0;
                if (redir_req) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_pc_v;
                    redir_req      = 1'b0;
                end
                if (beats_left > 0) begin
                    bus_respcyc = 1'b1;
                    bus_resp    = {word(beat_addr + 64'd4), word(beat_addr)};
                    if (beat_idx == redir_at_beat) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = redir_target;
                        redir_at_beat  = -1;
                    end
                    beat_addr  = beat_addr + 64'd8;
                    beat_idx++;
                    beats_left--;
                end else if (bus_reqcyc) begin
                    bus_reqack = 1'b1;
                    req_q.push_back(bus_req);
                    ack_resp_cnt.push_back(respack_cnt);
                    beat_addr  = bus_req;
                    beats_left = 8;
                    beat_idx   = 0;
                end
                if (out_valid && out_ready && !redirect_valid) begin
                    got_pc.push_back(out_pc);
                    got_insn.push_back(out_insn);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and first request.
        wait_cyc(2);
        check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("rst_req", bus_req, 64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("reqtag", 64'(bus_reqtag), 64'h1100);
        reset = 1'b1;
        wait_cyc(1);
        check("first_reqcyc", 64'(bus_reqcyc), 64'd1);
        check("first_req", bus_req, 64'h1000);

        // Aligned entry: one full line in order, then the next line.
        out_ready = 1'b1;
        for (int i = 0; i < 400 && (got_pc.size() < 16 || req_q.size() < 2); i++) wait_cyc(1);
        check("t1_count_ok", 64'(got_pc.size() >= 16), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_pc%0d", i), got_pc[i], 64'h1000 + 64'(4 * i));
            check($sformatf("t1_insn%0d", i), 64'(got_insn[i]), 64'(word(64'h1000 + 64'(4 * i))));
        end
        check("t1_req0", req_q[0], 64'h1000);
        check("t1_req1", req_q[1], 64'h1040);

        // Mid-line entry drops the lanes below it.
        do_reset(64'h1008);
        for (int i = 0; i < 400 && got_pc.size() < 15; i++) wait_cyc(1);
        check("t2_req0", req_q[0], 64'h1000);
        check("t2_pc0", got_pc[0], 64'h1008);
        check("t2_insn0", 64'(got_insn[0]), 64'(word(64'h1008)));
        check("t2_pc13", got_pc[13], 64'h103C);
        check("t2_pc14", got_pc[14], 64'h1040);

        // Stalled consumer: FIFO space allows exactly two bursts.
        out_ready = 1'b0;
        do_reset(64'h1000);
        wait_cyc(200);
        check("t3_reqs", 64'(req_q.size()), 64'd2);
        check("t3_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("t3_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && got_pc.size() < 32; i++) wait_cyc(1);
        check("t3_pc0", got_pc[0], 64'h1000);
        check("t3_pc16", got_pc[16], 64'h1040);
        check("t3_pc31", got_pc[31], 64'h107C);

        // Redirect at beat 3: rest of burst drained, FIFO flushed.
        out_ready     = 1'b0;
        redir_at_beat = 3;
        redir_target  = 64'h2004;
        do_reset(64'h1000);
        for (int i = 0; i < 200 && req_q.size() < 2; i++) wait_cyc(1);
        check("t4_req1", req_q[1], 64'h2000);
        check("t4_acks", 64'(ack_resp_cnt[1]), 64'd8);
        wait_cyc(30);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && got_pc.size() < 15; i++) wait_cyc(1);
        check("t4_pc0", got_pc[0], 64'h2004);
        check("t4_insn0", 64'(got_insn[0]), 64'(word(64'h2004)));
        check("t4_pc14", got_pc[14], 64'h203C);

        // Zero word at 0x1014.
        zero_en   = 1'b1;
        zero_addr = 64'h1014;
        do_reset(64'h1000);
`ifdef FETCH_ZERO_STOP_EN
        wait_cyc(150);
        check("t5_count", 64'(got_pc.size()), 64'd5);
        check("t5_pc4", got_pc[4], 64'h1010);
        check("t5_halted", 64'(halted), 64'd1);
        check("t5_reqs", 64'(req_q.size()), 64'd1);
        redir_pc_v = 64'h3000;
        redir_req  = 1'b1;
        wait_cyc(1);
        check("t5_unhalt", 64'(halted), 64'd0);
        for (int i = 0; i < 200 && got_pc.size() < 6; i++) wait_cyc(1);
        check("t5_req1", req_q[1], 64'h3000);
        check("t5_pc5", got_pc[5], 64'h3000);
`else
        for (int i = 0; i < 400 && got_pc.size() < 7; i++) wait_cyc(1);
        check("t5_pc5", got_pc[5], 64'h1014);
        check("t5_insn5", 64'(got_insn[5]), 64'd0);
        check("t5_pc6", got_pc[6], 64'h1018);
        check("t5_halted", 64'(halted), 64'd0);
`endif
        zero_en = 1'b0;

        // Reset asserted mid-burst.
        do_reset(64'h1000);
        for (int i = 0; i < 100 && beat_idx < 3; i++) wait_cyc(1);
        check("t6_in_burst", 64'(beat_idx >= 3), 64'd1);
        reset = 1'b0;
        entry = 64'h5008;
        #1;
        check("t6_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("t6_respack", 64'(bus_respack), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_req", bus_req, 64'd0);
        wait_cyc(3);
        clear_logs();
        reset = 1'b1;
        for (int i = 0; i < 100 && req_q.size() < 1; i++) wait_cyc(1);
        check("t6_req_after", req_q[0], 64'h5000);
        for (int i = 0; i < 200 && got_pc.size() < 1; i++) wait_cyc(1);
        check("t6_pc0", got_pc[0], 64'h5008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end. It issues line-sized burst reads on the Sysbus and splits each returned beat into instruction lanes. Instructions are buffered in a flushable FIFO and presented downstream one per cycle with their PC under a valid/ready handshake. A redirect input restarts fetch at any word-aligned address, discarding stale data.

## Interface
- BUS_DATA_WIDTH, 64: Sysbus data width; multiple of INSN_WIDTH.
- BUS_TAG_WIDTH, 13: Sysbus tag width.
- INSN_WIDTH, 32: instruction width; lanes per beat LANES = BUS_DATA_WIDTH/INSN_WIDTH.
- BURST_BEATS, 8: beats per line; LINE_BYTES = BURST_BEATS*BUS_DATA_WIDTH/8.
- FIFO_DEPTH, 32: instruction entries; power of two, ≥ BURST_BEATS*LANES.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry  in  64  start address; sampled while reset is low.
- bus_reqcyc  out  1  request valid.
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address.
- bus_reqtag  out  BUS_TAG_WIDTH  constant SYSBUS_READ<<12 | SYSBUS_MEMORY<<8.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  beat data; lane 0 = bits [INSN_WIDTH-1:0] = lowest address.
- bus_resptag  in  BUS_TAG_WIDTH  ignored.
- bus_respack  out  1  beat acknowledge.
- redirect_valid  in  1  restart fetch.
- redirect_pc  in  64  restart address.
- out_valid  out  1  out_insn/out_pc valid.
- out_ready  in  1  consumer accepts.
- out_insn  out  INSN_WIDTH  instruction.
- out_pc  out  64  its address.
- halted  out  1  fetch stopped (FETCH_ZERO_STOP_EN only; else tied 0).

## Operation
- Reset (low): fetch_pc ← entry; outputs bus_reqcyc=0, bus_req=0, bus_respack=0, out_valid=0, halted=0; FIFO empty; state IDLE.
- States: IDLE, REQ, RESP, DRAIN.
- IDLE → REQ when FIFO free entries ≥ BURST_BEATS*LANES, not halted, no redirect this cycle; bus_req ← fetch_pc & ~(LINE_BYTES-1), bus_reqcyc ← 1.
- REQ: hold bus_reqcyc/bus_req stable until bus_reqack; then deassert, → RESP (or DRAIN if redirect seen during REQ).
- RESP: each cycle with bus_respcyc is one beat; beat counter 0..BURST_BEATS-1. Lane address = line base + beat*BUS_DATA_WIDTH/8 + lane*INSN_WIDTH/8. Lanes with address < fetch_pc (first line only) are dropped; others pushed in lane order. After last beat: fetch_pc ← line base + LINE_BYTES (64-bit wrap), → IDLE.
- DRAIN: beats acknowledged and discarded; after last beat → IDLE with fetch_pc = latest redirect target.
- bus_respack: registered copy of bus_respcyc in RESP/DRAIN (one-cycle pulse per beat, following cycle).
- Redirect (any state): FIFO flushed same edge; fetch_pc ← redirect_pc with low log2(INSN_WIDTH/8) bits cleared; halted cleared. In RESP mid-burst → DRAIN. Coincident with last beat: beat discarded, → IDLE. Later redirect overrides earlier.
- Redirect and out_ready same cycle: redirect wins; popped entry discarded; out_valid=0 next cycle.
- FIFO: simultaneous push (up to LANES) and pop permitted; overflow impossible by issue rule; out_valid = !empty.

## Timing
- First bus_reqcyc: first rising edge after reset release.
- Beat captured at edge N → its first instruction valid on out_* after edge N (out_valid high cycle N+1 if FIFO was empty).
- Throughput: one instruction per cycle out; one outstanding burst at a time.
- Next request may issue the cycle after last beat if space allows.

## Configuration
- FETCH_ZERO_STOP_EN defined: an all-zero instruction lane in RESP is not pushed; later lanes of the burst dropped; remaining beats acked; halted ← 1 at burst end (sticky); no further requests until redirect or reset. Earlier FIFO contents still drain.
- Undefined: zero words are ordinary instructions; halted tied 0.

## Structure
- fetch_pkg: state enum, tag constant, derived LANES/LINE_BYTES helper functions.
- Sub-module fetch_fifo: LANES-wide push, single pop, synchronous flush, free-count output.

## Test plan
- entry=0x1000, memory words i = 0x13+i → bus_req=0x1000, 16 instructions out_pc 0x1000..0x103C in order, then bus_req=0x1040.
- entry=0x1008 → first out_pc 0x1008; 0x1000/0x1004 never output.
- out_ready=0 throughout, FIFO_DEPTH=32 → exactly two bursts, then bus_reqcyc stays 0.
- redirect_pc=0x2004 at beat 3 of a burst → remaining 4 beats acked, nothing pushed, next bus_req=0x2000, first out_pc 0x2004.
- FETCH_ZERO_STOP_EN, zero word at 0x1014 → outputs 0x1000..0x1010 only, halted=1, no further requests; redirect clears halted.
- reset asserted mid-RESP → outputs return to reset values immediately; after release, bus_req=entry line.
